// File: rtl/elevator_call_dispatcher_if.sv
// Call/dispatch bundle between the hall-call source, the dispatcher and the car controller.
// master = call source / car controller side, slave = dispatcher.
interface elevator_call_dispatcher_if #(
    parameter int NUM_FLOORS = 10
);
    logic                  call_valid;
    logic [3:0]            call_floor;
    logic                  call_ready;
    logic [3:0]            current_floor;
    logic                  car_idle;
    logic [3:0]            requested_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;
    logic                  door_open;
    logic                  call_err;

    modport master (
        output call_valid, call_floor, current_floor, car_idle,
        input  call_ready, requested_floor, pending, dir_up, door_open, call_err
    );

    modport slave (
        input  call_valid, call_floor, current_floor, car_idle,
        output call_ready, requested_floor, pending, dir_up, door_open, call_err
    );
endinterface

// File: rtl/elevator_call_dispatcher.sv
// SCAN-style elevator call dispatcher: latches hall calls, picks the next target in the sweep
// direction, holds the door for a fixed dwell. Target/state registered (1 cycle); calls never back-pressured.
module elevator_call_dispatcher #(
    parameter int NUM_FLOORS   = 10,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    elevator_call_dispatcher_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SERVE, DOOR} state_t;

    localparam int          CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [4:0]  NF = 5'(NUM_FLOORS);

    state_t                state_q;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [3:0]            requested_floor_q;
    logic                  dir_up_q;
    logic                  door_open_q;
    logic                  call_err_q;
    logic [CW-1:0]         dwell_q;

    logic                  call_acc, call_in_range;
    logic                  cur_pending, arrive, idle_hit, clr_en, retarget;
    logic [3:0]            clr_floor;
    logic                  up_found, dn_found;
    logic [3:0]            up_tgt, dn_tgt;
    logic [NUM_FLOORS-1:0] set_vec, clr_vec;

    always_comb begin
        call_acc      = bus.call_valid & rst_n;
        call_in_range = {1'b0, bus.call_floor} < NF;

        cur_pending = 1'b0;
        up_found    = 1'b0;
        up_tgt      = '0;
        dn_found    = 1'b0;
        dn_tgt      = '0;
        // Walk down for the closest floor above, up for the closest floor below.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && 4'(i) > bus.current_floor) begin
                up_found = 1'b1;
                up_tgt   = 4'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && 4'(i) < bus.current_floor) begin
                dn_found = 1'b1;
                dn_tgt   = 4'(i);
            end
            if (pending_q[i] && 4'(i) == bus.current_floor) cur_pending = 1'b1;
        end

        arrive    = (state_q == SERVE) && (bus.current_floor == requested_floor_q) && bus.car_idle;
        idle_hit  = (state_q == IDLE) && cur_pending;
        clr_en    = arrive || idle_hit;
        clr_floor = arrive ? requested_floor_q : bus.current_floor;

        retarget = (state_q == SERVE) && !arrive && call_acc && call_in_range &&
                   (dir_up_q ? (bus.current_floor < bus.call_floor && bus.call_floor < requested_floor_q)
                             : (requested_floor_q < bus.call_floor && bus.call_floor < bus.current_floor));

        set_vec = '0;
        clr_vec = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            // The floor the door is open at is already served.
            if (call_acc && bus.call_floor == 4'(i) &&
                !(state_q == DOOR && bus.call_floor == bus.current_floor))
                set_vec[i] = 1'b1;
            if (clr_en && clr_floor == 4'(i)) clr_vec[i] = 1'b1;
        end
        pending_d = (pending_q | set_vec) & ~clr_vec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            pending_q         <= '0;
            requested_floor_q <= '0;
            dir_up_q          <= 1'b1;
            door_open_q       <= 1'b0;
            call_err_q        <= 1'b0;
            dwell_q           <= '0;
        end else begin
            pending_q  <= pending_d;
            call_err_q <= call_acc && !call_in_range;
            case (state_q)
                IDLE: begin
                    if (pending_q == '0) begin
                        requested_floor_q <= bus.current_floor;
                    end else if (idle_hit) begin
                        state_q     <= DOOR;
                        dwell_q     <= CW'(DWELL_CYCLES - 1);
                        door_open_q <= 1'b1;
                    end else begin
                        state_q <= SERVE;
                        if (dir_up_q) begin
                            if (up_found) requested_floor_q <= up_tgt;
                            else begin
                                dir_up_q          <= 1'b0;
                                requested_floor_q <= dn_tgt;
                            end
                        end else begin
                            if (dn_found) requested_floor_q <= dn_tgt;
                            else begin
                                dir_up_q          <= 1'b1;
                                requested_floor_q <= up_tgt;
                            end
                        end
                    end
                end
                SERVE: begin
                    if (arrive) begin
                        state_q     <= DOOR;
                        dwell_q     <= CW'(DWELL_CYCLES - 1);
                        door_open_q <= 1'b1;
                    end else if (retarget) begin
                        requested_floor_q <= bus.call_floor;
                    end
                end
                DOOR: begin
                    if (dwell_q == '0) begin
                        state_q     <= IDLE;
                        door_open_q <= 1'b0;
                    end else begin
                        dwell_q <= dwell_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.call_ready      = rst_n;
    assign bus.requested_floor = requested_floor_q;
    assign bus.pending         = pending_q;
    assign bus.dir_up          = dir_up_q;
    assign bus.door_open       = door_open_q;
    assign bus.call_err        = call_err_q;
endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed bench for elevator_call_dispatcher (NUM_FLOORS=10, DWELL_CYCLES=8).
module tb_elevator_call_dispatcher;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    elevator_call_dispatcher_if #(.NUM_FLOORS(10)) bus ();

    elevator_call_dispatcher #(.NUM_FLOORS(10), .DWELL_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic call(input logic [3:0] f);
        bus.call_valid = 1'b1;
        bus.call_floor = f;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.call_valid    = 1'b0;
        bus.call_floor    = '0;
        bus.current_floor = '0;
        bus.car_idle      = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_pending",  32'(bus.pending), 32'h0);
        check("rst_req",      32'(bus.requested_floor), 32'd0);
        check("rst_dir",      32'(bus.dir_up), 32'd1);
        check("rst_door",     32'(bus.door_open), 32'd0);
        check("rst_err",      32'(bus.call_err), 32'd0);
        check("rst_ready",    32'(bus.call_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_run",    32'(bus.call_ready), 32'd1);

        // Floor 0, call 3, serve, dwell 8 cycles
        call(4'd3);
        tick();
        bus.call_valid = 1'b0;
        check("c3_pending",   32'(bus.pending), 32'h008);
        tick();
        check("c3_req",       32'(bus.requested_floor), 32'd3);
        check("c3_dir",       32'(bus.dir_up), 32'd1);
        check("c3_door_srv",  32'(bus.door_open), 32'd0);
        bus.current_floor = 4'd3;
        tick();
        check("c3_door_on",   32'(bus.door_open), 32'd1);
        check("c3_cleared",   32'(bus.pending), 32'h0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("c3_dwell",  32'(bus.door_open), 32'd1);
        end
        tick();
        check("c3_door_off",  32'(bus.door_open), 32'd0);

        // Floor 5 going up: calls 7 and 2, 7 first then reverse to 2
        bus.current_floor = 4'd5;
        tick();
        check("idle_req_cur", 32'(bus.requested_floor), 32'd5);
        call(4'd7);
        tick();
        call(4'd2);
        tick();
        bus.call_valid = 1'b0;
        check("s33_req7",     32'(bus.requested_floor), 32'd7);
        check("s33_dir_up",   32'(bus.dir_up), 32'd1);
        check("s33_pend",     32'(bus.pending), 32'h084);
        bus.current_floor = 4'd7;
        tick();
        check("s33_door7",    32'(bus.door_open), 32'd1);
        check("s33_pend2",    32'(bus.pending), 32'h004);
        repeat (8) tick();
        check("s33_idle",     32'(bus.door_open), 32'd0);
        tick();
        check("s33_req2",     32'(bus.requested_floor), 32'd2);
        check("s33_dir_dn",   32'(bus.dir_up), 32'd0);

        // Reset mid-SERVE with a call held during reset
        rst_n = 1'b0;
        call(4'd3);
        #1;
        check("mid_ready",    32'(bus.call_ready), 32'd0);
        tick();
        check("mid_pending",  32'(bus.pending), 32'h0);
        check("mid_req",      32'(bus.requested_floor), 32'd0);
        check("mid_dir",      32'(bus.dir_up), 32'd1);
        check("mid_door",     32'(bus.door_open), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.call_valid = 1'b0;
        bus.current_floor = 4'd1;
        tick();
        check("post_pending", 32'(bus.pending), 32'h0);
        check("post_req",     32'(bus.requested_floor), 32'd1);

        // SERVE to 8 from floor 1, call 4 retargets, call 6 does not
        call(4'd8);
        tick();
        bus.call_valid = 1'b0;
        check("s34_pend8",    32'(bus.pending), 32'h100);
        tick();
        check("s34_req8",     32'(bus.requested_floor), 32'd8);
        call(4'd4);
        tick();
        check("s34_req4",     32'(bus.requested_floor), 32'd4);
        check("s34_pend",     32'(bus.pending), 32'h110);
        call(4'd6);
        tick();
        check("s34_noretgt",  32'(bus.requested_floor), 32'd4);
        check("s34_pend6",    32'(bus.pending), 32'h150);

        // Out-of-range call: one-cycle error pulse, pending untouched
        call(4'd12);
        tick();
        bus.call_valid = 1'b0;
        check("err_pulse",    32'(bus.call_err), 32'd1);
        check("err_pend",     32'(bus.pending), 32'h150);
        tick();
        check("err_clear",    32'(bus.call_err), 32'd0);

        // Car at 4 but busy: no stop
        bus.current_floor = 4'd4;
        bus.car_idle      = 1'b0;
        tick();
        check("busy_door",    32'(bus.door_open), 32'd0);
        check("busy_pend",    32'(bus.pending), 32'h150);

        // Arrival at 4 with a call to 4 on the clearing edge and throughout dwell
        bus.car_idle = 1'b1;
        call(4'd4);
        tick();
        check("d36_door",     32'(bus.door_open), 32'd1);
        check("d36_clrwins",  32'(bus.pending), 32'h140);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("d36_dwell", 32'(bus.door_open), 32'd1);
            check("d36_pend",  32'(bus.pending), 32'h140);
        end
        tick();
        bus.call_valid = 1'b0;
        check("d36_idle",     32'(bus.door_open), 32'd0);
        check("d36_pend_end", 32'(bus.pending), 32'h140);
        tick();
        check("d36_next6",    32'(bus.requested_floor), 32'd6);
        check("d36_dir",      32'(bus.dir_up), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/elevator_call_dispatcher.md
ELEVATOR_CALL_DISPATCHER -- requirements
Module: elevator_call_dispatcher

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 10, number of served floors (0..NUM_FLOORS-1, max 16).
REQ-002 SHALL have parameter DWELL_CYCLES, default 8, door-open cycles per stop (>=1).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port call_valid  input  1  call request strobe.
REQ-006 SHALL have port call_floor  input  4  floor of requested call.
REQ-007 SHALL have port call_ready  output  1  call accepted when call_valid & call_ready.
REQ-008 SHALL have port current_floor  input  4  floor reported by the elevator controller.
REQ-009 SHALL have port car_idle  input  1  high when the elevator controller is in its IDLE state.
REQ-010 SHALL have port requested_floor  output  4  target floor driven to the elevator controller (registered).
REQ-011 SHALL have port pending  output  NUM_FLOORS  bitmap of outstanding calls (registered).
REQ-012 SHALL have port dir_up  output  1  current sweep direction, 1=up.
REQ-013 SHALL have port door_open  output  1  high during dwell at a served floor.
REQ-014 SHALL have port call_err  output  1  one-cycle pulse when an out-of-range call is accepted.

Function
REQ-015 SHALL implement three states: IDLE, SERVE, DOOR.
REQ-016 call_ready SHALL be 1 in every non-reset cycle; calls are never back-pressured.
REQ-017 Accepted call with call_floor < NUM_FLOORS SHALL set pending[call_floor] visible next cycle; call_floor >= NUM_FLOORS SHALL leave pending unchanged and pulse call_err next cycle.
REQ-018 Duplicate call to an already-pending floor SHALL have no further effect.
REQ-019 IDLE, pending==0: stay IDLE, requested_floor = current_floor, dir_up unchanged.
REQ-020 IDLE, pending[current_floor]==1: go to DOOR next cycle, clear that bit.
REQ-021 IDLE, other pending: target = nearest pending floor in dir_up direction; if none that way, invert dir_up and take nearest in new direction; load requested_floor, go SERVE; requested_floor valid 1 cycle after the IDLE decision cycle.
REQ-022 SERVE: hold requested_floor; when current_floor==requested_floor and car_idle==1, go DOOR, clear pending[requested_floor] same edge.
REQ-023 SERVE retarget: call accepted for floor strictly between current_floor and requested_floor in travel direction SHALL replace requested_floor next cycle; original target stays pending.
REQ-024 DOOR: door_open=1 for exactly DWELL_CYCLES cycles (down-counter), then IDLE.
REQ-025 Call to current_floor accepted while in DOOR SHALL not set pending (already served).
REQ-026 Call accepted in the same cycle its bit is cleared SHALL resolve to cleared (clear wins).
REQ-027 door_open SHALL be 0 in IDLE and SERVE.
REQ-028 Floor comparisons unsigned 4-bit; no wrap-around of target selection beyond 0 or NUM_FLOORS-1.

Reset
REQ-029 rst_n==0 at a rising edge SHALL force state IDLE, pending=0, requested_floor=0, dir_up=1, door_open=0, call_err=0, dwell counter=0, call_ready=0 during that cycle.
REQ-030 Reset mid-SERVE or mid-DOOR SHALL discard all pending calls and dwell count; no state survives.
REQ-031 A call presented during reset SHALL be ignored.

Verification
REQ-032 current_floor=0, call 3 -> pending=0x008 next cycle, requested_floor=3, dir_up=1; at current_floor=3 & car_idle -> door_open high 8 cycles, pending=0.
REQ-033 current_floor=5, dir_up=1, calls 2 and 7 -> serve 7 first, then dir_up=0 and requested_floor=2.
REQ-034 SERVE target 8 from floor 1, call 4 accepted -> requested_floor=4 next cycle, pending bit 8 remains set.
REQ-035 call_floor=12 with NUM_FLOORS=10 -> call_err one-cycle pulse, pending unchanged.
REQ-036 DOOR at floor 4, call 4 same cycle as clear and during dwell -> pending[4] stays 0, returns IDLE after dwell.
REQ-037 rst_n low during SERVE with pending=0x0A0 -> next cycle pending=0, requested_floor=0, dir_up=1, state IDLE.
